// File: rtl/dot_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dot_seq_ctrl_if
//  Brief    : Job, operand-buffer read and result handshake bundle for the
//             dot-product sequencer. The slave modport is the sequencer side;
//             the master modport is the job issuer / buffer / DSP side.
//  Revision : 1.0 - initial release
// ============================================================================
interface dot_seq_ctrl_if #(
  parameter int AW = 10
) ();

  logic          start;
  logic [AW:0]   len;
  logic [AW-1:0] wei_base;
  logic [AW-1:0] fm_base;
  logic          rd_en;
  logic [AW-1:0] wei_addr;
  logic [AW-1:0] fm_addr;
  logic [15:0]   res;
  logic [15:0]   acc_out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          ovf;

  modport master (
    output start, len, wei_base, fm_base, res, out_ready,
    input  rd_en, wei_addr, fm_addr, acc_out, out_valid, busy, ovf
  );

  modport slave (
    input  start, len, wei_base, fm_base, res, out_ready,
    output rd_en, wei_addr, fm_addr, acc_out, out_valid, busy, ovf
  );

endinterface
`default_nettype wire

// File: rtl/dot_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dot_seq_ctrl
//  Brief    : Dot-product job sequencer. Issues len consecutive operand-buffer
//             reads, tracks them through the buffer + DSP latency with a valid
//             shift register, accumulates the DSP results and presents the
//             job result on a valid/ready handshake.
//  Options  : DOTSEQ_SAT_EN - saturating signed accumulation with sticky ovf;
//             when undefined the sum wraps modulo 2^16 and ovf is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module dot_seq_ctrl #(
  parameter int N_MUL = 3,
  parameter int AW    = 10,
  parameter int LAT   = 7
) (
  input  logic          clk,
  input  logic          rstn,
  dot_seq_ctrl_if.slave bus
);

  // One cycle of buffer read latency ahead of the DSP pipeline.
  localparam int            c_PIPE_D   = 1 + LAT;
  localparam logic [AW:0]   c_ONE_LEN  = (AW+1)'(1);
  localparam logic [AW-1:0] c_ONE_ADDR = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  generate
    if (N_MUL < 1 || LAT < 0) begin : g_param_chk
      $error("dot_seq_ctrl: N_MUL must be >= 1 and LAT must be >= 0");
    end
  endgenerate

  state_t                r_state, w_state_nxt;
  logic [AW:0]           r_left, w_left_nxt;
  logic [AW-1:0]         r_wei_addr, w_wei_addr_nxt;
  logic [AW-1:0]         r_fm_addr, w_fm_addr_nxt;
  logic                  r_rd_en, w_rd_en_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [15:0]           r_acc_out, w_acc_out_nxt;
  logic                  w_start_job;
  logic [c_PIPE_D-1:0]   r_valid, w_valid_nxt;
  logic [15:0]           r_acc, w_acc_sum, w_acc_final;
  logic                  w_add;

  // Read tracking: the strobe issued this cycle enters the pipe at the bottom.
  assign w_valid_nxt = c_PIPE_D'({r_valid, r_rd_en});
  assign w_add       = r_valid[c_PIPE_D-1];

`ifdef DOTSEQ_SAT_EN
  logic [16:0] w_sum_ext;
  logic        w_clamp;
  logic        r_ovf;

  // Signed add with clamp to the 16-bit range on overflow.
  always_comb begin
    w_sum_ext = {r_acc[15], r_acc} + {bus.res[15], bus.res};
    w_clamp   = 1'b0;
    w_acc_sum = w_sum_ext[15:0];
    if (w_sum_ext[16] != w_sum_ext[15]) begin
      w_clamp   = 1'b1;
      w_acc_sum = w_sum_ext[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Sticky clamp flag, cleared when a new job is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_start_job) begin
      r_ovf <= 1'b0;
    end else if (w_add && w_clamp) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign w_acc_sum = r_acc + bus.res;
  assign bus.ovf   = 1'b0;
`endif

  assign w_acc_final = w_add ? w_acc_sum : r_acc;

  // Next-state and registered-output decode for the job sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_left_nxt      = r_left;
    w_wei_addr_nxt  = r_wei_addr;
    w_fm_addr_nxt   = r_fm_addr;
    w_rd_en_nxt     = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_acc_out_nxt   = r_acc_out;
    w_start_job     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start_job    = 1'b1;
          w_left_nxt     = bus.len;
          w_wei_addr_nxt = bus.wei_base;
          w_fm_addr_nxt  = bus.fm_base;
          if (bus.len == '0) begin
            w_state_nxt     = DONE;
            w_out_valid_nxt = 1'b1;
            w_acc_out_nxt   = '0;
          end else begin
            w_state_nxt = ISSUE;
            w_rd_en_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        // r_left counts the read on the bus this cycle.
        if (r_left == c_ONE_LEN) begin
          w_state_nxt = DRAIN;
        end else begin
          w_left_nxt     = r_left - c_ONE_LEN;
          w_wei_addr_nxt = r_wei_addr + c_ONE_ADDR;
          w_fm_addr_nxt  = r_fm_addr + c_ONE_ADDR;
          w_rd_en_nxt    = 1'b1;
        end
      end
      DRAIN: begin
        // Leave as the last tracked result is folded in, capturing the total.
        if (w_valid_nxt == '0) begin
          w_state_nxt     = DONE;
          w_out_valid_nxt = 1'b1;
          w_acc_out_nxt   = w_acc_final;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, read-issue and result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_left      <= '0;
      r_wei_addr  <= '0;
      r_fm_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_left      <= w_left_nxt;
      r_wei_addr  <= w_wei_addr_nxt;
      r_fm_addr   <= w_fm_addr_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_acc_out   <= w_acc_out_nxt;
    end
  end

  // Valid shift register and running accumulator.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      r_acc   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_acc   <= w_start_job ? 16'h0000 : w_acc_final;
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.wei_addr  = r_wei_addr;
  assign bus.fm_addr   = r_fm_addr;
  assign bus.acc_out   = r_acc_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dot_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dot_seq_ctrl
//  Brief    : Self-checking bench for dot_seq_ctrl. A buffer + DSP stand-in
//             returns a per-address result after the read and DSP latency;
//             a job-level reference model predicts read strobes, addresses,
//             completion cycle, result and overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dot_seq_ctrl;

  localparam int AW     = 10;
  localparam int LAT    = 7;
  localparam int N_MUL  = 3;
  localparam int PIPE_D = LAT + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  dot_seq_ctrl_if #(.AW(AW)) bus ();

  dot_seq_ctrl #(
    .N_MUL (N_MUL),
    .AW    (AW),
    .LAT   (LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Buffer + DSP stand-in: result depends on the addresses that were read.
  bit          const_mode = 1'b0;
  logic [15:0] res_const  = 16'h0000;
  logic [15:0] seed       = 16'h0000;

  function automatic logic [15:0] res_of(input logic [AW-1:0] wa, input logic [AW-1:0] fa);
    logic [31:0] h;
    if (const_mode) return res_const;
    h = (32'(wa) * 32'd40503) ^ (32'(fa) * 32'd977) ^ 32'(seed);
    return h[15:0] ^ h[31:16];
  endfunction

  logic [15:0] dly [PIPE_D];

  always @(posedge clk) begin
    for (int i = PIPE_D - 1; i > 0; i--) dly[i] <= dly[i-1];
    dly[0] <= bus.rd_en ? res_of(bus.wei_addr, bus.fm_addr) : 16'hBAD0;
  end

  assign bus.res = dly[PIPE_D-1];

  // Reference result for a whole job: {ovf, acc}.
  function automatic logic [16:0] ref_job(input int L, input logic [AW-1:0] wb, input logic [AW-1:0] fb);
    int          s;
    bit          o;
    logic [15:0] r;
    s = 0;
    o = 1'b0;
    for (int k = 0; k < L; k++) begin
      r = res_of(AW'(int'(wb) + k), AW'(int'(fb) + k));
`ifdef DOTSEQ_SAT_EN
      s = s + int'($signed(r));
      if (s > 32767) begin
        s = 32767;
        o = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        o = 1'b1;
      end
`else
      s = (s + int'(r)) % 65536;
`endif
    end
    return {o, 16'(s)};
  endfunction

  // Job-level model: start cycle, length, bases and expected result.
  bit            m_job = 1'b0, m_rd_exp = 1'b0, m_ov_exp = 1'b0, m_rst = 1'b0, m_ovf = 1'b0;
  int            m_s = 0, m_len = 0, m_d = 0, m_tdone = 0;
  logic [AW-1:0] m_wb = '0, m_fb = '0;
  logic [15:0]   m_acc = '0;
  logic [16:0]   m_ref;

  always @(posedge clk) begin
    if (!rstn) begin
      m_job = 1'b0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (!m_job) begin
        if (bus.start) begin
          m_job   = 1'b1;
          m_s     = cyc;
          m_len   = int'(bus.len);
          m_wb    = bus.wei_base;
          m_fb    = bus.fm_base;
          m_tdone = (m_len == 0) ? 1 : m_len + LAT + 2;
          m_ref   = ref_job(m_len, m_wb, m_fb);
          m_acc   = m_ref[15:0];
          m_ovf   = m_ref[16];
        end
      end else if (m_ov_exp && bus.out_ready) begin
        m_job = 1'b0;
      end
    end
    cyc++;
    m_d      = cyc - m_s;
    m_rd_exp = m_job && (m_d >= 1) && (m_d <= m_len);
    m_ov_exp = m_job && (m_d >= m_tdone);
  end

  // Per-cycle comparison of all observable outputs against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk_val("rd_en", 32'(bus.rd_en), 32'(m_rd_exp));
      chk_val("busy", 32'(bus.busy), 32'(m_job));
      chk_val("out_valid", 32'(bus.out_valid), 32'(m_ov_exp));
      if (m_rd_exp) begin
        chk_val("wei_addr", 32'(bus.wei_addr), 32'((int'(m_wb) + m_d - 1) % (1 << AW)));
        chk_val("fm_addr", 32'(bus.fm_addr), 32'((int'(m_fb) + m_d - 1) % (1 << AW)));
      end
      if (m_ov_exp) begin
        chk_val("acc_out", 32'(bus.acc_out), 32'(m_acc));
        chk_val("ovf", 32'(bus.ovf), 32'(m_ovf));
      end
      if (m_rst) begin
        chk_val("rst_wei_addr", 32'(bus.wei_addr), 32'd0);
        chk_val("rst_fm_addr", 32'(bus.fm_addr), 32'd0);
        chk_val("rst_acc_out", 32'(bus.acc_out), 32'd0);
        chk_val("rst_ovf", 32'(bus.ovf), 32'd0);
      end
    end
  end

  task automatic jitter();
    bus.start    = 1'($urandom_range(0, 1));
    bus.len      = (AW+1)'($urandom_range(0, 1 << AW));
    bus.wei_base = AW'($urandom);
    bus.fm_base  = AW'($urandom);
  endtask

  task automatic run_job(input int L, input int wb, input int fb, input int rdy_dly, input bit noise);
    int n;
    n = 0;
    while (m_job && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.start    = 1'b1;
    bus.len      = (AW+1)'(L);
    bus.wei_base = AW'(wb);
    bus.fm_base  = AW'(fb);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!m_ov_exp && n < L + LAT + 20) begin
      if (noise) jitter();
      @(negedge clk);
      n++;
    end
    if (!m_ov_exp) begin
      chk_val("done_timeout", 32'(bus.out_valid), 32'd1);
    end else begin
      repeat (rdy_dly) begin
        if (noise) jitter();
        @(negedge clk);
      end
      bus.out_ready = 1'b1;
      bus.start     = noise;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
    end
  endtask

  initial begin
    int n;
    int L;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.wei_base  = '0;
    bus.fm_base   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Four words of constant 0x0030.
    const_mode = 1'b1;
    res_const  = 16'h0030;
    run_job(4, 'h010, 'h200, 2, 1'b0);
    chk_val("dir_acc_4x30", 32'(bus.acc_out), 32'h00C0);

    // Empty job.
    run_job(0, 5, 7, 1, 1'b0);
    chk_val("dir_acc_len0", 32'(bus.acc_out), 32'h0000);

    // Consumer stalls 20 cycles while start and job inputs toggle.
    const_mode = 1'b0;
    seed       = 16'h1234;
    run_job(5, 100, 200, 20, 1'b1);

    // Address wrap at the top of the buffer.
    run_job(4, 'h3FE, 'h3FD, 0, 1'b0);

    // Reset while the third read is on the bus.
    bus.start    = 1'b1;
    bus.len      = (AW+1)'(6);
    bus.wei_base = AW'(40);
    bus.fm_base  = AW'(80);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (m_d < 3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_val("pre_rst_rd_en", 32'(bus.rd_en), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk_val("post_rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk_val("post_rst_busy", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);

    // Two words of 0x7000: clamps or wraps depending on the build.
    const_mode = 1'b1;
    res_const  = 16'h7000;
    run_job(2, 0, 0, 1, 1'b0);
`ifdef DOTSEQ_SAT_EN
    chk_val("dir_sat_acc", 32'(bus.acc_out), 32'h7FFF);
    chk_val("dir_sat_ovf", 32'(bus.ovf), 32'd1);
`else
    chk_val("dir_wrap_acc", 32'(bus.acc_out), 32'hE000);
    chk_val("dir_wrap_ovf", 32'(bus.ovf), 32'd0);
`endif

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      const_mode = ($urandom_range(0, 3) == 0);
      res_const  = $urandom_range(0, 1) ? 16'(16'h6000 + $urandom_range(0, 16'h1FFF))
                                        : 16'(16'h8000 + $urandom_range(0, 16'h1FFF));
      seed       = 16'($urandom);
      L          = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 40));
      run_job(L, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no completion, expected finish before 50000 cycles");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/dot_seq_ctrl.md
DOT_SEQ_CTRL -- requirements
Module: dot_seq_ctrl

Interface
REQ-001 SHALL have parameter N_MUL, default 3: operand lanes per word; each word is 16*N_MUL bits.
REQ-002 SHALL have parameter AW, default 10: operand buffer address width.
REQ-003 SHALL have parameter LAT, default 7: cycles from the DSP group sampling operands to its res output.
REQ-004 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-005 SHALL have port rstn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: job request, sampled only in IDLE.
REQ-007 SHALL have port len, input, AW+1: words in the job, 0..2^AW.
REQ-008 SHALL have ports wei_base and fm_base, input, AW each: buffer start addresses.
REQ-009 SHALL have port rd_en, output, 1: shared read strobe to the weight and feature-map buffers.
REQ-010 SHALL have ports wei_addr and fm_addr, output, AW each: read addresses.
REQ-011 SHALL have port res, input, 16: DSP group summed result.
REQ-012 SHALL have port acc_out, output, 16: job result.
REQ-013 SHALL have port out_valid, output, 1: acc_out valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts acc_out.
REQ-015 SHALL have ports busy and ovf, output, 1 each: busy is high in any state other than IDLE; ovf is the sticky saturation flag.

Function
REQ-016 SHALL run a four-state FSM: IDLE, ISSUE, DRAIN, DONE.
REQ-017 SHALL, on IDLE with start=1, latch len and both base addresses, clear acc and ovf, and go to ISSUE; if len=0 it SHALL go to DONE instead.
REQ-018 SHALL, in ISSUE, assert rd_en for exactly len consecutive cycles; the k-th read uses addresses base+k (k=0..len-1), wrapping modulo 2^AW; the FSM SHALL then go to DRAIN.
REQ-019 SHALL track reads with a valid shift register of depth PIPE_D=1+LAT, allowing 1 cycle for buffer read latency.
REQ-020 SHALL add res to acc on every cycle the valid-register output is high; the sum is 16-bit two's complement.
REQ-021 SHALL, in DRAIN, go to DONE on the cycle after the valid register becomes all-zero.
REQ-022 SHALL, in DONE, hold out_valid=1 and a stable acc_out until out_ready=1, then go to IDLE; out_valid falls the cycle after the handshake.
REQ-023 SHALL ignore start in every state except IDLE; changes to len or the base addresses during a job have no effect.
REQ-024 SHALL, if start and the out_ready handshake coincide, not accept the new job before IDLE is reached (one cycle later).

Reset
REQ-025 SHALL, while rstn=0 at a clock edge, force: FSM to IDLE; valid register, acc, acc_out, ovf, rd_en, out_valid and busy to 0; both addresses to 0.
REQ-026 SHALL, on reset mid-job, abandon the job; no rd_en and no out_valid follow until a new start.

Configuration
REQ-027 SHALL compile saturation logic only when DOTSEQ_SAT_EN is defined: signed accumulation clamps to 0x7FFF/0x8000, and ovf sets on any clamp and stays set until the next job start.
REQ-028 SHALL, when DOTSEQ_SAT_EN is undefined, wrap accumulation modulo 2^16 and tie ovf to 0.

Verification
REQ-029 SHALL cover: LAT=7, len=4, all weight lanes 0x0200, all fm lanes 0x0010, res model 0x0030/word -> rd_en high cycles 1-4 after start, addresses base..base+3, out_valid first high cycle 13, acc_out=0x00C0.
REQ-030 SHALL cover: len=0 start -> no rd_en, out_valid on cycle 1 after start, acc_out=0x0000.
REQ-031 SHALL cover: out_ready held low 20 cycles in DONE -> acc_out stable, start pulses ignored, IDLE only after out_ready=1.
REQ-032 SHALL cover: wei_base=0x3FE, len=4 -> wei_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-033 SHALL cover: rstn low for 1 cycle during ISSUE at k=2 -> rd_en 0 next cycle, busy 0, no out_valid afterwards.
REQ-034 SHALL cover: res model 0x7000 per word, len=2 -> with DOTSEQ_SAT_EN acc_out=0x7FFF and ovf=1; without it acc_out=0xE000 and ovf=0.
